// File: rtl/vga_fb_arbiter_pkg.sv
// Shared constants and types for the framebuffer arbiter: framebuffer geometry,
// RAM word shape and the display phase encoding.
package vga_fb_arbiter_pkg;

  localparam int unsigned FB_WORDS     = 120000;
  localparam int unsigned PIX_PER_WORD = 4;
  localparam int unsigned FB_ADDR_W    = 17;
  localparam int unsigned FB_DATA_W    = 16;

  typedef enum logic [1:0] {
    VBLANK,
    LINE,
    HBLANK
  } fb_phase_t;

endpackage

// File: rtl/vga_fb_arbiter_if.sv
// Drawing-engine write port: valid/ready handshake with address and data.
// The writer drives the master side, the arbiter the slave side.
interface vga_fb_arbiter_if #(
  parameter int unsigned ADDR_W = 17,
  parameter int unsigned DATA_W = 16
);

  logic              wr_valid;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              wr_ready;

  modport master (
    output wr_valid,
    output wr_addr,
    output wr_data,
    input  wr_ready
  );

  modport slave (
    input  wr_valid,
    input  wr_addr,
    input  wr_data,
    output wr_ready
  );

endinterface

// File: rtl/vga_fb_arbiter_rd_pipe.sv
// Display read-return path: delays the slot flag by RD_LAT+1 cycles and captures
// the RAM read word in step with it.
module vga_fb_arbiter_rd_pipe #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned RD_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              slot_i,
  input  logic [DATA_W-1:0] rdata_i,
  output logic [DATA_W-1:0] word_o,
  output logic              valid_o
);

  logic [RD_LAT:0]   flag_q;
  logic [DATA_W-1:0] word_q;

  // flag_q[RD_LAT-1] marks the cycle the RAM output holds the fetched word
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      flag_q <= '0;
      word_q <= '0;
    end else begin
      flag_q <= {flag_q[RD_LAT-1:0], slot_i};
      if (flag_q[RD_LAT-1]) begin
        word_q <= rdata_i;
      end
    end
  end

  assign word_o  = word_q;
  assign valid_o = flag_q[RD_LAT];

endmodule

// File: rtl/vga_fb_arbiter.sv
// Single-port framebuffer arbiter: display fetch owns every 4th active pixel slot,
// the draw engine gets the rest. Define VGA_FB_ARB_BLANK_ONLY_EN to confine writes to vblank.
module vga_fb_arbiter
  import vga_fb_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W = FB_ADDR_W,
  parameter int unsigned DATA_W = FB_DATA_W,
  parameter int unsigned RD_LAT = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [10:0]            hcount_i,
  input  logic [10:0]            vcount_i,
  input  logic                   hblnk_i,
  input  logic                   vblnk_i,
  vga_fb_arbiter_if.slave        wr_if,
  output logic [ADDR_W-1:0]      ram_addr_o,
  output logic                   ram_we_o,
  output logic [DATA_W-1:0]      ram_wdata_o,
  input  logic [DATA_W-1:0]      ram_rdata_i,
  output logic [DATA_W-1:0]      pix_word_o,
  output logic                   pix_valid_o,
  output logic                   frame_start_o
);

  localparam int unsigned SlotW = $clog2(PIX_PER_WORD);

  fb_phase_t         phase_d, phase_q;
  logic [ADDR_W-1:0] fa_d, fa_q, fetch_addr;
  logic              slot, at_origin, frame_start_q;

  always_comb begin
    phase_d = HBLANK;
    if (vblnk_i) begin
      phase_d = VBLANK;
    end else if (!hblnk_i) begin
      phase_d = LINE;
    end
  end

  assign slot      = !rst && (phase_d == LINE) && (hcount_i[SlotW-1:0] == '0);
  assign at_origin = (hcount_i == 11'd0) && (vcount_i == 11'd0);
  // The frame origin is itself a slot, so it reads word 0 and leaves fa at 1
  assign fetch_addr = at_origin ? '0 : fa_q;

  always_comb begin
    fa_d = fa_q;
    if (slot) begin
      fa_d = fetch_addr + ADDR_W'(1);
    end else if (at_origin) begin
      fa_d = '0;
    end
  end

`ifdef VGA_FB_ARB_BLANK_ONLY_EN
  assign wr_if.wr_ready = !rst && !slot && (phase_d == VBLANK);
`else
  assign wr_if.wr_ready = !rst && !slot;
`endif

  always_comb begin
    ram_addr_o  = '0;
    ram_we_o    = 1'b0;
    ram_wdata_o = '0;
    if (slot) begin
      ram_addr_o = fetch_addr;
    end else if (wr_if.wr_ready && wr_if.wr_valid) begin
      ram_addr_o  = wr_if.wr_addr;
      ram_we_o    = 1'b1;
      ram_wdata_o = wr_if.wr_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      phase_q       <= VBLANK;
      fa_q          <= '0;
      frame_start_q <= 1'b0;
    end else begin
      phase_q       <= phase_d;
      fa_q          <= fa_d;
      frame_start_q <= at_origin;
    end
  end

  assign frame_start_o = frame_start_q;

  // A frame never fetches more than the framebuffer holds
  assert property (@(posedge clk) disable iff (rst)
                   (phase_q == VBLANK) |-> (fa_q <= ADDR_W'(FB_WORDS)));

  vga_fb_arbiter_rd_pipe #(
    .DATA_W(DATA_W),
    .RD_LAT(RD_LAT)
  ) u_rd_pipe (
    .clk    (clk),
    .rst    (rst),
    .slot_i (slot),
    .rdata_i(ram_rdata_i),
    .word_o (pix_word_o),
    .valid_o(pix_valid_o)
  );

endmodule

// File: tb/tb_vga_fb_arbiter.sv
// Scoreboard bench for vga_fb_arbiter: a compressed-frame timing driver with a random
// writer feeds a reference model; a negedge monitor compares the DUT against it.
module tb_vga_fb_arbiter;
  import vga_fb_arbiter_pkg::*;

  localparam int unsigned AW    = FB_ADDR_W;
  localparam int unsigned DW    = FB_DATA_W;
  localparam int unsigned MEM_N = 1 << AW;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [10:0]   hcount = '0;
  logic [10:0]   vcount = '0;
  logic          hblnk = 1'b0;
  logic          vblnk = 1'b1;
  logic [AW-1:0] ram_addr;
  logic          ram_we;
  logic [DW-1:0] ram_wdata, ram_rdata, pix_word;
  logic          pix_valid, frame_start;

  vga_fb_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) wr_bus ();

  vga_fb_arbiter #(.ADDR_W(AW), .DATA_W(DW), .RD_LAT(1)) dut (
    .clk          (clk),
    .rst          (rst),
    .hcount_i     (hcount),
    .vcount_i     (vcount),
    .hblnk_i      (hblnk),
    .vblnk_i      (vblnk),
    .wr_if        (wr_bus),
    .ram_addr_o   (ram_addr),
    .ram_we_o     (ram_we),
    .ram_wdata_o  (ram_wdata),
    .ram_rdata_i  (ram_rdata),
    .pix_word_o   (pix_word),
    .pix_valid_o  (pix_valid),
    .frame_start_o(frame_start)
  );

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] pat(input int unsigned a);
    return DW'(a * 7 + 3);
  endfunction

  // Registered-output RAM; unwritten words read back the background pattern
  logic [DW-1:0] ram_mem [MEM_N];
  bit            ram_wr  [MEM_N];
  always @(posedge clk) begin
    if (ram_we) begin
      ram_mem[ram_addr] <= ram_wdata;
      ram_wr[ram_addr]  <= 1'b1;
    end
    ram_rdata <= ram_wr[ram_addr] ? ram_mem[ram_addr] : pat(32'(ram_addr));
  end

  typedef struct {
    bit            ready;
    bit            fs;
    bit            we;
    bit            rd;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
  } cyc_t;

  typedef struct {
    int unsigned   cyc;
    logic [DW-1:0] word;
    bit            tag;
  } pix_t;

  cyc_t cyc_q[$];
  pix_t pix_q[$];

  logic [DW-1:0] ref_mem [MEM_N];
  int unsigned   fetch_cnt;   // display words fetched since frame origin or reset
  bit            prev_origin = 1'b0;
  bit            prev_rst    = 1'b1;
  bit            w_pend      = 1'b0;
  logic [AW-1:0] w_addr      = '0;
  logic [DW-1:0] w_data      = '0;
  bit            tag_next    = 1'b0;
  logic [DW-1:0] tagged_word = '0;
  int unsigned   cycle       = 0;
  int            n_reads     = 0;
  int            n_pix       = 0;
  int            n_we_seen   = 0;
  int            n_pass      = 0;
  int            n_checks    = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cycle);
  endtask

  // One pixel clock: drive timing + writer, and record what the DUT must do
  task automatic step(input int v, input int h, input bit r, input int wmode);
    cyc_t e;
    pix_t p;
    bit   slot, ready, origin;
    @(posedge clk);
    #1;
    cycle++;
    rst    = r;
    hcount = 11'(h);
    vcount = 11'(v);
    hblnk  = (h >= 800);
    vblnk  = (v >= 600);
    slot   = !r && (h < 800) && (v < 600) && (h % PIX_PER_WORD == 0);
    origin = (h == 0) && (v == 0);
    if (r) begin
      n_reads -= pix_q.size();
      pix_q.delete();
    end
    if (!w_pend && (wmode == 2 || (wmode == 1 && $urandom_range(3, 0) == 0))) begin
      w_pend = 1'b1;
      w_addr = AW'($urandom_range(MEM_N - 1, 0));
      w_data = DW'($urandom);
    end
    wr_bus.wr_valid = w_pend;
    wr_bus.wr_addr  = w_addr;
    wr_bus.wr_data  = w_data;
`ifdef VGA_FB_ARB_BLANK_ONLY_EN
    ready = !r && !slot && (v >= 600);
`else
    ready = !r && !slot;
`endif
    e.ready = ready;
    e.fs    = !r && !prev_rst && prev_origin;
    e.rd    = slot;
    e.we    = ready && w_pend;
    e.addr  = '0;
    e.wdata = '0;
    if (r || origin) fetch_cnt = 0;
    if (slot) begin
      e.addr   = AW'(fetch_cnt);
      p.cyc    = cycle + 2;
      p.word   = ref_mem[fetch_cnt];
      p.tag    = tag_next;
      tag_next = 1'b0;
      pix_q.push_back(p);
      n_reads++;
      fetch_cnt++;
    end
    if (e.we) begin
      e.addr          = w_addr;
      e.wdata         = w_data;
      ref_mem[w_addr] = w_data;
      w_pend          = 1'b0;
    end
    cyc_q.push_back(e);
    prev_origin = origin;
    prev_rst    = r;
  endtask

  task automatic run_line(input int v, input int wmode);
    for (int h = 0; h < 1056; h++) step(v, h, 1'b0, wmode);
  endtask

  task automatic check_idle();
    #3;
    check("idle_ram_we", 32'(ram_we), 32'(0));
    check("idle_ram_addr", 32'(ram_addr), 32'(0));
    check("idle_ram_wdata", 32'(ram_wdata), 32'(0));
    check("idle_pix_word", 32'(pix_word), 32'(0));
    check("idle_pix_valid", 32'(pix_valid), 32'(0));
    check("idle_frame_start", 32'(frame_start), 32'(0));
    check("idle_wr_ready", 32'(wr_bus.wr_ready), 32'(0));
  endtask

  always @(negedge clk) begin
    cyc_t e;
    pix_t p;
    if (cyc_q.size() != 0) begin
      e = cyc_q.pop_front();
      check("wr_ready", 32'(wr_bus.wr_ready), 32'(e.ready));
      check("frame_start", 32'(frame_start), 32'(e.fs));
      check("ram_we", 32'(ram_we), 32'(e.we));
      if (e.we || e.rd) check("ram_addr", 32'(ram_addr), 32'(e.addr));
      if (e.we) check("ram_wdata", 32'(ram_wdata), 32'(e.wdata));
    end
    if (ram_we) n_we_seen++;
    if (pix_valid) begin
      n_pix++;
      if (pix_q.size() == 0) begin
        check("pix_spurious", 32'(pix_valid), 32'(0));
      end else begin
        p = pix_q.pop_front();
        check("pix_cycle", cycle, p.cyc);
        check("pix_word", 32'(pix_word), 32'(p.word));
        if (p.tag) tagged_word = pix_word;
      end
    end
  end

  initial begin
    int we0, pix0, rd0;
    for (int i = 0; i < int'(MEM_N); i++) ref_mem[i] = pat(i);
    wr_bus.wr_valid = 1'b0;
    wr_bus.wr_addr  = '0;
    wr_bus.wr_data  = '0;

    for (int i = 0; i < 3; i++) step(627, 1050 + i, 1'b1, 0);
    check_idle();
    for (int h = 1053; h < 1056; h++) step(627, h, 1'b0, 0);

    // Frame 1 (compressed: a few active lines, then a full vblank)
    run_line(0, 1);
    run_line(1, 1);
    for (int h = 0; h < 1056; h++) begin
      if (h == 4 && !w_pend) begin
        w_pend = 1'b1;
        w_addr = AW'(17'h00123);
        w_data = 16'hBEEF;
      end
      step(2, h, 1'b0, 0);
`ifndef VGA_FB_ARB_BLANK_ONLY_EN
      if (h == 4) begin
        #3;
        check("slot_hold_ready", 32'(wr_bus.wr_ready), 32'(0));
        check("slot_hold_we", 32'(ram_we), 32'(0));
      end
      if (h == 5) begin
        #3;
        check("late_accept_we", 32'(ram_we), 32'(1));
        check("late_accept_addr", 32'(ram_addr), 32'h00123);
        check("late_accept_data", 32'(ram_wdata), 32'hBEEF);
      end
`endif
    end
    for (int h = 0; h < 1056; h++) begin
      if (h == 900 && !w_pend) begin
        w_pend = 1'b1;
        w_addr = AW'(17'h1F000);
        w_data = 16'h1234;
      end
      step(10, h, 1'b0, 0);
    end
    run_line(598, 1);
    run_line(599, 1);
    @(negedge clk);
    #1;
    we0 = n_we_seen;
    for (int v = 600; v < 628; v++) run_line(v, 2);
    @(negedge clk);
    #1;
    check("vblank_writes", 32'(n_we_seen - we0), 32'(28 * 1056));
    check("frame1_pix", 32'(n_pix), 32'(6 * 200));

    // Frame 2: pattern write/read-back, then a mid-frame reset
    pix0 = n_pix;
    rd0  = n_reads;
    for (int h = 0; h < 1056; h++) begin
      if (h == 800 && !w_pend) begin
        w_pend = 1'b1;
        w_addr = AW'(200);
        w_data = 16'hA5A5;
      end
      step(0, h, 1'b0, 0);
    end
    tag_next = 1'b1;
    run_line(1, 0);
`ifndef VGA_FB_ARB_BLANK_ONLY_EN
    check("readback_a5a5", 32'(tagged_word), 32'hA5A5);
`endif
    run_line(2, 1);
    for (int h = 0; h < 1056; h++) begin
      step(300, h, (h >= 100 && h < 103), 1);
      if (h == 101) check_idle();
    end
    @(negedge clk);
    #1;
    we0 = n_pix;
    run_line(301, 1);
    @(negedge clk);
    #1;
    check("pix_resume_line", 32'(n_pix - we0), 32'(200));
    run_line(598, 1);
    run_line(599, 1);
    run_line(600, 1);
    run_line(627, 1);
    @(negedge clk);
    #1;
    check("frame2_pix", 32'(n_pix - pix0), 32'(n_reads - rd0));

    // Frame 3: fetch realigns to word 0 at the origin
    step(0, 0, 1'b0, 1);
    #3;
    check("realign_addr", 32'(ram_addr), 32'(0));
    for (int h = 1; h < 1056; h++) step(0, h, 1'b0, 1);
    run_line(1, 1);
    @(negedge clk);
    #1;
    check("pix_drained", 32'(pix_q.size()), 32'(0));
    check("cyc_drained", 32'(cyc_q.size()), 32'(0));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/vga_fb_arbiter.md
Name: vga_fb_arbiter

Overview:
- Shares one single-port framebuffer RAM between two requesters: the VGA display fetch and a drawing engine writer.
- Sits between vga_timing (hcount/vcount/blank inputs), the framebuffer RAM and the draw engine, in the 40 MHz, 800x600 pixel domain.
- Display fetch has absolute priority. The writer gets every slot the display does not use.

Parameters:
- ADDR_W, 17, RAM word-address width (120000 words used).
- DATA_W, 16, RAM word width; one word = 4 pixels of 4 bits.
- RD_LAT, 1, RAM read latency in cycles (registered output RAM).

Ports:
- clk  in  1  pixel clock, 40 MHz
- rst  in  1  asynchronous reset, active-high
- hcount  in  11  horizontal counter from vga_timing (0..1055)
- vcount  in  11  vertical counter from vga_timing (0..627)
- hblnk  in  1  horizontal blank
- vblnk  in  1  vertical blank
- wr_valid  in  1  writer request
- wr_addr  in  ADDR_W  writer word address
- wr_data  in  DATA_W  writer data
- wr_ready  out  1  writer slot available this cycle
- ram_addr  out  ADDR_W  RAM address
- ram_we  out  1  RAM write enable
- ram_wdata  out  DATA_W  RAM write data
- ram_rdata  in  DATA_W  RAM read data
- pix_word  out  DATA_W  fetched display word
- pix_valid  out  1  pix_word is valid this cycle
- frame_start  out  1  one-cycle pulse at hcount==0, vcount==0

Behaviour:
- Reset is asynchronous, active-high. Outputs after reset:
  - ram_we=0, ram_addr=0, ram_wdata=0, pix_word=0.
  - pix_valid=0, frame_start=0, wr_ready=0.
  - fetch address counter fa=0.
- Display slot: asserted when !hblnk && !vblnk && hcount[1:0]==2'b00.
  - This gives 200 slots per active line and 120000 per frame.
- State FSM, derived from the timing inputs and registered:
  - VBLANK when vblnk=1.
  - LINE when the slot condition region is active (hblnk=0, vblnk=0).
  - HBLANK otherwise.
  - Transitions follow the inputs with no extra conditions.
- In a display slot:
  - ram_addr=fa, ram_we=0, wr_ready=0.
  - fa increments by 1 the same cycle.
- Frame start: when hcount==0 && vcount==0, fa loads 0. This takes priority over increment.
  - fa must equal 120000 at the start of each vblank; wrap is only through the frame-start reload.
- Non-display slot:
  - wr_ready=1, combinational from the slot condition.
  - If wr_valid also: ram_addr=wr_addr, ram_we=1, ram_wdata=wr_data, all in the same cycle. This is a zero-latency accept.
  - Writer must hold valid/addr/data stable until ready.
  - No write is ever lost or duplicated.
- Read return:
  - pix_valid is the display-slot flag delayed by RD_LAT+1 cycles; pix_word = ram_rdata captured with it.
  - Total latency is 2 cycles from slot to pix_valid at RD_LAT=1. Downstream delays its timing by 2.
- Simultaneous slot and write request: the display wins and the writer waits. At most 1 wait cycle in LINE.
- Writer address out of range (>=120000) is passed through unchecked.
- Reset mid-frame: the pipeline is flushed and fa=0.
  - The fetch stream realigns at the next frame_start.
  - The reads in between use fa counting from 0; this is accepted.
- frame_start is registered and pulses for one cycle, one cycle after hcount==0 && vcount==0.

Optional Feature:
- Macro: VGA_FB_ARB_BLANK_ONLY_EN.
- Defined: wr_ready=1 only while vblnk=1 and no display slot is active. Writes during LINE or HBLANK of active lines are held off, which gives tear-free updates.
- Undefined: writes are allowed in any non-display slot, as above.

Decomposition:
- vga_pkg gains:
  - FB_WORDS=120000.
  - PIX_PER_WORD=4.
  - FB_ADDR_W=17.
  - FB_DATA_W=16.
  - typedef enum {VBLANK, LINE, HBLANK} fb_phase_t.
- Sub-module vga_fb_rd_pipe: a RD_LAT+1 delay line for the slot flag plus the data capture register.

Test Plan:
- Reset, then run 2 full frames with wr_valid=0 -> exactly 120000 pix_valid pulses per frame. The first read address is 0 at vcount=0, hcount=0, and the last is 119999 at vcount=599, hcount=796. pix_valid appears 2 cycles after each slot.
- wr_valid=1 held at hcount=4 (a display slot) in LINE, addr=0x00123, data=0xBEEF -> wr_ready=0 at hcount=4; write accepted at hcount=5 with ram_we=1, ram_addr=0x00123, ram_wdata=0xBEEF.
- Continuous writer during vblank, lines 600..627 -> wr_ready=1 on every cycle and 28*1056=29568 writes accepted.
- With VGA_FB_ARB_BLANK_ONLY_EN defined, writer asserted at vcount=10, hcount=900 -> no accept until vcount=600, hcount=0.
- Assert rst at vcount=300 for 3 cycles -> all outputs return to 0 while rst is high. pix_valid resumes within 1 line. fa reloads to 0 at the next frame_start.
- Model RAM with write-then-read of pattern word 0xA5A5 at address 200 -> pix_word=0xA5A5 on the pix_valid for vcount=1, hcount=0.
